// File: rtl/bft_leaf_port.sv
// Leaf-side BFT port: 1-cycle registered TX toward the leaf, FWFT RX FIFO toward the switch, IDLE/RUN/DRAIN control.
// TX backpressure is state-only (s_ready in RUN); a full RX FIFO drops the packet, pulses resend and counts the drop.
module bft_leaf_port #(
    parameter int RX_DEPTH = 4,
    parameter int PKT_W    = 49
) (
    input  logic             clk_400,
    input  logic             reset_400,
    input  logic [PKT_W-2:0] s_pkt,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [PKT_W-1:0] dout_bft2leaf,
    input  logic [PKT_W-1:0] din_leaf2bft,
    output logic             resend,
    output logic             ap_start,
    output logic [PKT_W-2:0] m_pkt,
    output logic             m_valid,
    input  logic             m_ready,
    input  logic             start_req,
    input  logic             stop_req,
    output logic [15:0]      drop_cnt
);
    localparam int AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int CW = $clog2(RX_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [PKT_W-2:0] mem [RX_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             rx_vld;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic             drop;

    assign rx_vld     = din_leaf2bft[PKT_W-1];
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(RX_DEPTH));
    assign pop        = !fifo_empty && m_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the packet.
    assign push       = rx_vld && (!fifo_full || pop);
    assign drop       = rx_vld && fifo_full && !pop;

    assign ap_start = (state == RUN);
    assign s_ready  = (state == RUN);
    assign m_valid  = !fifo_empty;
    assign m_pkt    = fifo_empty ? '0 : mem[rd_ptr];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_req) state_nxt = RUN;
            RUN:     if (stop_req) state_nxt = DRAIN;
            // Leave only once nothing is queued and nothing is arriving from the leaf.
            DRAIN:   if (fifo_empty && !rx_vld) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_400 or negedge reset_400) begin
        if (!reset_400) begin
            state         <= IDLE;
            dout_bft2leaf <= '0;
            resend        <= 1'b0;
            drop_cnt      <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
        end else begin
            state         <= state_nxt;
            dout_bft2leaf <= (s_valid && s_ready) ? {1'b1, s_pkt} : '0;
            resend        <= drop;
            if (drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_400) begin
        if (push) begin
            mem[wr_ptr] <= din_leaf2bft[PKT_W-2:0];
        end
    end
endmodule

// File: tb/tb_bft_leaf_port.sv
module tb_bft_leaf_port;
    localparam int DEPTH  = 4;
    localparam int PW     = 49;
    localparam int PL     = PW - 1;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DRN  = 2;

    logic          clk_400 = 1'b0;
    logic          reset_400;
    logic [PL-1:0] s_pkt;
    logic          s_valid;
    logic          s_ready;
    logic [PW-1:0] dout_bft2leaf;
    logic [PW-1:0] din_leaf2bft;
    logic          resend;
    logic          ap_start;
    logic [PL-1:0] m_pkt;
    logic          m_valid;
    logic          m_ready;
    logic          start_req;
    logic          stop_req;
    logic [15:0]   drop_cnt;

    always #5 clk_400 = ~clk_400;

    bft_leaf_port #(.RX_DEPTH(DEPTH), .PKT_W(PW)) dut (
        .clk_400(clk_400), .reset_400(reset_400),
        .s_pkt(s_pkt), .s_valid(s_valid), .s_ready(s_ready),
        .dout_bft2leaf(dout_bft2leaf), .din_leaf2bft(din_leaf2bft),
        .resend(resend), .ap_start(ap_start),
        .m_pkt(m_pkt), .m_valid(m_valid), .m_ready(m_ready),
        .start_req(start_req), .stop_req(stop_req), .drop_cnt(drop_cnt)
    );

    int vectors = 0;
    int errors  = 0;

    // Reference model: operating mode, queue of held payloads, expected registered outputs.
    int            mode;
    logic [PL-1:0] rxq [$];
    logic [PW-1:0] e_dout;
    logic          e_resend;
    logic [15:0]   e_drop;

    task automatic model_reset();
        mode     = M_IDLE;
        rxq      = {};
        e_dout   = '0;
        e_resend = 1'b0;
        e_drop   = '0;
    endtask

    task automatic model_edge();
        bit pop, push, drop;
        if (!reset_400) begin
            model_reset();
            return;
        end
        pop  = (rxq.size() != 0) && m_ready;
        push = din_leaf2bft[PW-1];
        drop = push && (rxq.size() == DEPTH) && !pop;
        e_dout   = (mode == M_RUN && s_valid) ? {1'b1, s_pkt} : '0;
        e_resend = drop;
        if (drop && e_drop != 16'hFFFF) e_drop = e_drop + 16'd1;
        if (mode == M_IDLE && start_req) mode = M_RUN;
        else if (mode == M_RUN && stop_req) mode = M_DRN;
        else if (mode == M_DRN && rxq.size() == 0 && !push) mode = M_IDLE;
        if (pop) void'(rxq.pop_front());
        if (push && !drop) rxq.push_back(din_leaf2bft[PL-1:0]);
    endtask

    task automatic tick();
        @(posedge clk_400);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        s_pkt        = '0;
        s_valid      = 1'b0;
        din_leaf2bft = '0;
        m_ready      = 1'b0;
        start_req    = 1'b0;
        stop_req     = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_400 = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_400);
        #1;
        reset_400 = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (ap_start !== 1'b0) begin errors++; $display("FAIL reset_ap_start got %b want 0", ap_start); end
        vectors++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %b want 0", s_ready); end
        vectors++; if (dout_bft2leaf !== '0) begin errors++; $display("FAIL reset_dout got %h want 0", dout_bft2leaf); end
        vectors++; if (resend !== 1'b0) begin errors++; $display("FAIL reset_resend got %b want 0", resend); end
        vectors++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
        vectors++; if (m_pkt !== '0) begin errors++; $display("FAIL reset_m_pkt got %h want 0", m_pkt); end
        vectors++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
        stop_req = 1'b1;
        tick();
        stop_req = 1'b0;
        tick();
        vectors++; if (ap_start !== 1'b0) begin errors++; $display("FAIL idle_stop_ignored ap_start got %b want 0", ap_start); end
        do_reset();
    endtask

    task automatic test_tx();
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        vectors++; if (ap_start !== 1'b1) begin errors++; $display("FAIL start_ap_start got %b want 1", ap_start); end
        vectors++; if (s_ready !== 1'b1) begin errors++; $display("FAIL start_s_ready got %b want 1", s_ready); end
        s_pkt   = 48'h0000_1234_5678;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        vectors++; if (dout_bft2leaf !== 49'h1_0000_1234_5678) begin errors++; $display("FAIL tx_dout got %h want 1000012345678", dout_bft2leaf); end
        tick();
        vectors++; if (dout_bft2leaf !== '0) begin errors++; $display("FAIL tx_dout_idle got %h want 0", dout_bft2leaf); end
    endtask

    task automatic test_rx_overflow();
        logic [PL-1:0] p [5];
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            p[i] = PL'({$urandom(), $urandom()});
            din_leaf2bft = {1'b1, p[i]};
            tick();
            if (i == 3) begin
                vectors++; if (resend !== 1'b0) begin errors++; $display("FAIL ovf_no_early_resend got %b want 0", resend); end
            end
        end
        din_leaf2bft = '0;
        vectors++; if (resend !== 1'b1) begin errors++; $display("FAIL ovf_resend got %b want 1", resend); end
        vectors++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL ovf_drop_cnt got %0d want 1", drop_cnt); end
        tick();
        vectors++; if (resend !== 1'b0) begin errors++; $display("FAIL ovf_resend_width got %b want 0", resend); end
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++; if (m_valid !== 1'b1 || m_pkt !== p[i]) begin errors++; $display("FAIL ovf_order[%0d] got v=%b %h want v=1 %h", i, m_valid, m_pkt, p[i]); end
            tick();
        end
        m_ready = 1'b0;
        vectors++; if (m_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b want 0", m_valid); end
    endtask

    task automatic test_full_pushpop();
        logic [PL-1:0] p [12];
        for (int i = 0; i < 12; i++) p[i] = PL'({$urandom(), $urandom()});
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            din_leaf2bft = {1'b1, p[i]};
            tick();
        end
        m_ready = 1'b1;
        for (int i = 4; i < 12; i++) begin
            din_leaf2bft = {1'b1, p[i]};
            vectors++; if (m_valid !== 1'b1 || m_pkt !== p[i-4]) begin errors++; $display("FAIL full_pp_head[%0d] got v=%b %h want v=1 %h", i, m_valid, m_pkt, p[i-4]); end
            tick();
            vectors++; if (resend !== 1'b0 || drop_cnt !== 16'd1) begin errors++; $display("FAIL full_pp_nodrop[%0d] got resend=%b cnt=%0d want 0/1", i, resend, drop_cnt); end
        end
        din_leaf2bft = '0;
        for (int j = 0; j < 4; j++) begin
            vectors++; if (m_valid !== 1'b1 || m_pkt !== p[8+j]) begin errors++; $display("FAIL full_pp_tail[%0d] got v=%b %h want v=1 %h", j, m_valid, m_pkt, p[8+j]); end
            tick();
        end
        m_ready = 1'b0;
        vectors++; if (m_valid !== 1'b0) begin errors++; $display("FAIL full_pp_empty got %b want 0", m_valid); end
    endtask

    task automatic test_drain();
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din_leaf2bft = {1'b1, PL'({$urandom(), $urandom()})};
            tick();
        end
        din_leaf2bft = '0;
        stop_req = 1'b1;
        tick();
        stop_req = 1'b0;
        vectors++; if (ap_start !== 1'b0 || s_ready !== 1'b0) begin errors++; $display("FAIL drain_enter got ap=%b rdy=%b want 0/0", ap_start, s_ready); end
        start_req = 1'b1;
        m_ready   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (m_valid !== 1'b1) begin errors++; $display("FAIL drain_pending[%0d] got %b want 1", i, m_valid); end
            tick();
            vectors++; if (ap_start !== 1'b0) begin errors++; $display("FAIL drain_start_ignored[%0d] got %b want 0", i, ap_start); end
        end
        vectors++; if (m_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b want 0", m_valid); end
        tick();
        vectors++; if (ap_start !== 1'b0) begin errors++; $display("FAIL drain_to_idle got %b want 0", ap_start); end
        tick();
        vectors++; if (ap_start !== 1'b1) begin errors++; $display("FAIL idle_restart got %b want 1", ap_start); end
        start_req = 1'b0;
        m_ready   = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [PL-1:0] c;
        c = PL'({$urandom(), $urandom()});
        m_ready = 1'b0;
        din_leaf2bft = {1'b1, PL'({$urandom(), $urandom()})};
        tick();
        din_leaf2bft = {1'b1, PL'({$urandom(), $urandom()})};
        s_pkt   = c;
        s_valid = 1'b1;
        tick();
        clear_inputs();
        vectors++; if (dout_bft2leaf !== {1'b1, c} || m_valid !== 1'b1) begin errors++; $display("FAIL mid_pre got dout=%h v=%b want %h v=1", dout_bft2leaf, m_valid, {1'b1, c}); end
        #2;
        reset_400 = 1'b0;
        #1;
        model_reset();
        vectors++; if (dout_bft2leaf !== '0 || m_valid !== 1'b0 || m_pkt !== '0) begin errors++; $display("FAIL mid_async_data got dout=%h v=%b pkt=%h want 0", dout_bft2leaf, m_valid, m_pkt); end
        vectors++; if (ap_start !== 1'b0 || s_ready !== 1'b0 || resend !== 1'b0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL mid_async_ctl got ap=%b rdy=%b rs=%b cnt=%0d want 0", ap_start, s_ready, resend, drop_cnt); end
        @(posedge clk_400);
        #3;
        reset_400 = 1'b1;
        tick();
        vectors++; if (m_valid !== 1'b0 || resend !== 1'b0 || drop_cnt !== 16'd0 || dout_bft2leaf !== '0) begin errors++; $display("FAIL mid_after got v=%b rs=%b cnt=%0d dout=%h want 0", m_valid, resend, drop_cnt, dout_bft2leaf); end
    endtask

    task automatic test_random();
        logic [PL-1:0] exp_m;
        for (int c = 0; c < 600; c++) begin
            start_req    = ($urandom_range(0, 9) == 0);
            stop_req     = ($urandom_range(0, 11) == 0);
            s_valid      = $urandom_range(0, 1) == 1;
            s_pkt        = PL'({$urandom(), $urandom()});
            din_leaf2bft = {($urandom_range(0, 9) < 6), PL'({$urandom(), $urandom()})};
            m_ready      = ($urandom_range(0, 9) < 4);
            tick();
            exp_m = (rxq.size() != 0) ? rxq[0] : '0;
            vectors++; if (ap_start !== (mode == M_RUN)) begin errors++; $display("FAIL rnd_ap_start c=%0d got %b want %b", c, ap_start, mode == M_RUN); end
            vectors++; if (s_ready !== (mode == M_RUN)) begin errors++; $display("FAIL rnd_s_ready c=%0d got %b want %b", c, s_ready, mode == M_RUN); end
            vectors++; if (dout_bft2leaf !== e_dout) begin errors++; $display("FAIL rnd_dout c=%0d got %h want %h", c, dout_bft2leaf, e_dout); end
            vectors++; if (resend !== e_resend) begin errors++; $display("FAIL rnd_resend c=%0d got %b want %b", c, resend, e_resend); end
            vectors++; if (m_valid !== (rxq.size() != 0)) begin errors++; $display("FAIL rnd_m_valid c=%0d got %b want %b", c, m_valid, rxq.size() != 0); end
            vectors++; if (m_pkt !== exp_m) begin errors++; $display("FAIL rnd_m_pkt c=%0d got %h want %h", c, m_pkt, exp_m); end
            vectors++; if (drop_cnt !== e_drop) begin errors++; $display("FAIL rnd_drop_cnt c=%0d got %0d want %0d", c, drop_cnt, e_drop); end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_tx();
        test_rx_overflow();
        test_full_pushpop();
        test_drain();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/bft_leaf_port.md
BFT_LEAF_PORT -- requirements
Module: bft_leaf_port

Interface
REQ-001 Parameter RX_DEPTH, default 4: RX FIFO entries (power of two, 2..16).
REQ-002 Parameter PKT_W, default 49: BFT packet width; bit PKT_W-1 = valid flag, bits PKT_W-2:0 = payload.
REQ-003 clk_400  input  1  sole clock; all logic on rising edge.
REQ-004 reset_400  input  1  asynchronous, active-low reset.
REQ-005 s_pkt  input  PKT_W-1  payload from BFT switch toward leaf.
REQ-006 s_valid  input  1  s_pkt valid.
REQ-007 s_ready  output  1  port accepts s_pkt this cycle.
REQ-008 dout_bft2leaf  output  PKT_W  packet into leaf (drives leaf din_leaf_bft2interface).
REQ-009 din_leaf2bft  input  PKT_W  packet from leaf (leaf dout_leaf_interface2bft).
REQ-010 resend  output  1  request leaf to retransmit dropped packet.
REQ-011 ap_start  output  1  leaf run enable.
REQ-012 m_pkt  output  PKT_W-1  RX payload toward BFT switch.
REQ-013 m_valid  output  1  m_pkt valid.
REQ-014 m_ready  input  1  switch consumes m_pkt.
REQ-015 start_req  input  1  one-cycle request to start leaf.
REQ-016 stop_req  input  1  one-cycle request to stop leaf.
REQ-017 drop_cnt  output  16  dropped-RX-packet count.

Function
REQ-018 FSM states IDLE, RUN, DRAIN; ap_start = 1 only in RUN (registered).
REQ-019 IDLE -> RUN on start_req; stop_req ignored in IDLE.
REQ-020 RUN -> DRAIN on stop_req; start_req ignored in RUN and DRAIN.
REQ-021 DRAIN -> IDLE in the cycle after RX FIFO empty and din_leaf2bft[PKT_W-1] = 0.
REQ-022 TX: s_ready = 1 only in RUN; leaf always accepts, so no TX backpressure beyond state.
REQ-023 TX: s_valid & s_ready -> dout_bft2leaf = {1'b1, s_pkt} next cycle (latency 1); otherwise dout_bft2leaf = 0.
REQ-024 TX: leaving RUN blocks new accepts; packet already registered is still driven for its one cycle.
REQ-025 RX: din_leaf2bft[PKT_W-1] = 1 -> payload pushed into FIFO if not full, in all states.
REQ-026 RX FIFO first-word fall-through: m_valid = not empty, m_pkt = head; pop on m_valid & m_ready.
REQ-027 Push and pop same cycle when full: push accepted, occupancy unchanged, no drop.
REQ-028 Push when full without pop: packet dropped, resend = 1 next cycle for exactly one cycle.
REQ-029 Drops in consecutive cycles produce resend high in the following consecutive cycles.
REQ-030 drop_cnt increments by 1 per drop, saturates at 16'hFFFF.
REQ-031 Pointers wrap modulo RX_DEPTH; occupancy counter width clog2(RX_DEPTH+1); order preserved.
REQ-032 Incoming packets with valid bit 0 ignored regardless of payload.

Reset
REQ-033 reset_400 low asynchronously forces: state IDLE, FIFO empty, s_ready 0, dout_bft2leaf 0, resend 0, ap_start 0, m_valid 0, m_pkt 0, drop_cnt 0.
REQ-034 Reset mid-operation discards FIFO contents and any in-flight TX packet; no resend generated for them.
REQ-035 First start_req honoured on the first clock edge after reset_400 deasserts.

Verification
REQ-036 Reset, start_req pulse -> ap_start 1 one cycle later, s_ready 1; s_pkt=48'h0000_1234_5678 valid -> dout_bft2leaf=49'h1_0000_1234_5678 next cycle, then 0.
REQ-037 m_ready=0, leaf sends 5 valid packets back-to-back (RX_DEPTH=4) -> packets 1-4 held in order, 5th dropped, resend pulse 1 cycle after 5th, drop_cnt=1.
REQ-038 FIFO full, m_ready=1 with new valid packet same cycle -> accepted, no resend, drop_cnt unchanged, order preserved through wrap over 12 packets.
REQ-039 RUN, 3 packets in RX FIFO, stop_req -> ap_start 0, s_ready 0 next cycle; state stays DRAIN until 3 pops, IDLE the cycle after empty.
REQ-040 FIFO holding 2 packets, TX packet in flight, reset_400 low mid-cycle -> all outputs 0 immediately, m_valid 0 after release, drop_cnt 0.
